// File: rtl/stepper_out_bank.sv
// Bank of step/dir/enable motor output channels with per-channel pulse timing,
// endstop blocking and sticky overrun/blocked flags, configured over the executor register bus.
module stepper_out_bank #(
    parameter int                    CHANNELS    = 12,
    parameter int                    ADDR_WIDTH  = 6,
    parameter logic [ADDR_WIDTH-1:0] REG_BASE    = 6'd8,
    parameter int                    TIMER_WIDTH = 16,
    parameter int                    DEF_PULSE   = 50,
    parameter int                    DEF_SETUP   = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_data,
    input  logic                  reg_stb,
    output logic                  reg_busy,
    input  logic [CHANNELS-1:0]   step_req,
    input  logic [CHANNELS-1:0]   dir_req,
    input  logic [CHANNELS-1:0]   endstop,
    output logic [CHANNELS-1:0]   mot_step,
    output logic [CHANNELS-1:0]   mot_dir,
    output logic [CHANNELS-1:0]   mot_enable,
    output logic [CHANNELS-1:0]   overrun,
    output logic [CHANNELS-1:0]   blocked
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_LOW} state_t;

    logic [CHANNELS-1:0]    enable_reg, dir_inv_reg, es_mask_reg, es_pol_reg;
    logic [CHANNELS-1:0]    es_meta_reg, es_sync_reg, es_active;
    logic [CHANNELS-1:0]    overrun_reg, blocked_reg, ovr_set, blk_set, idle;
    logic [TIMER_WIDTH-1:0] pulse_reg, setup_reg, pulse_eff, setup_eff;
    logic                   pend_valid_reg;
    logic [2:0]             pend_off_reg;
    logic [31:0]            pend_data_reg;

    logic [ADDR_WIDTH:0]    addr_off;
    logic                   addr_hit, wr_accept, hold_wr, commit_pend, wr_en;
    logic [2:0]             wr_off;
    logic [31:0]            wr_data;
    logic [CHANNELS-1:0]    clear_mask;
    logic                   unused_bits;

    // Widened subtraction so addresses below REG_BASE wrap to a large value and miss.
    assign addr_off    = {1'b0, reg_addr} - {1'b0, REG_BASE};
    assign addr_hit    = addr_off < (ADDR_WIDTH+1)'(7);
    assign wr_accept   = reg_stb && !pend_valid_reg && addr_hit;
    assign hold_wr     = wr_accept && (addr_off[2:0] == 3'd2 || addr_off[2:0] == 3'd3) && !(&idle);
    assign commit_pend = pend_valid_reg && (&idle);
    assign wr_en       = (wr_accept && !hold_wr) || commit_pend;
    assign wr_off      = pend_valid_reg ? pend_off_reg : addr_off[2:0];
    assign wr_data     = pend_valid_reg ? pend_data_reg : reg_data;
    assign clear_mask  = (wr_en && wr_off == 3'd6) ? wr_data[CHANNELS-1:0] : '0;
    assign unused_bits = ^wr_data;

    assign pulse_eff  = (pulse_reg == '0) ? TIMER_WIDTH'(1) : pulse_reg;
    assign setup_eff  = (setup_reg == '0) ? TIMER_WIDTH'(1) : setup_reg;
    assign es_active  = es_sync_reg ^ es_pol_reg;

    assign reg_busy   = pend_valid_reg;
    assign mot_enable = ~enable_reg;
    assign overrun    = overrun_reg;
    assign blocked    = blocked_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg     <= '0;
            dir_inv_reg    <= '0;
            es_mask_reg    <= '0;
            es_pol_reg     <= '0;
            pulse_reg      <= TIMER_WIDTH'(DEF_PULSE);
            setup_reg      <= TIMER_WIDTH'(DEF_SETUP);
            pend_valid_reg <= 1'b0;
            pend_off_reg   <= '0;
            pend_data_reg  <= '0;
            overrun_reg    <= '0;
            blocked_reg    <= '0;
            es_meta_reg    <= '0;
            es_sync_reg    <= '0;
        end else begin
            es_meta_reg <= endstop;
            es_sync_reg <= es_meta_reg;
            if (hold_wr) begin
                pend_valid_reg <= 1'b1;
                pend_off_reg   <= addr_off[2:0];
                pend_data_reg  <= reg_data;
            end else if (commit_pend) begin
                pend_valid_reg <= 1'b0;
            end
            if (wr_en) begin
                case (wr_off)
                    3'd0:    enable_reg  <= wr_data[CHANNELS-1:0];
                    3'd1:    dir_inv_reg <= wr_data[CHANNELS-1:0];
                    3'd2:    pulse_reg   <= wr_data[TIMER_WIDTH-1:0];
                    3'd3:    setup_reg   <= wr_data[TIMER_WIDTH-1:0];
                    3'd4:    es_mask_reg <= wr_data[CHANNELS-1:0];
                    3'd5:    es_pol_reg  <= wr_data[CHANNELS-1:0];
                    default: ;
                endcase
            end
            // A set in the same cycle as a clear wins.
            overrun_reg <= (overrun_reg & ~clear_mask) | ovr_set;
            blocked_reg <= (blocked_reg & ~clear_mask) | blk_set;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t                 state_reg, state_next;
        logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
        logic                   dir_reg, dir_next, d, ovr_c, blk_c, step_c, idle_c;

        assign d = dir_req[gi] ^ dir_inv_reg[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                state_reg <= ST_IDLE;
                timer_reg <= '0;
                dir_reg   <= 1'b0;
            end else begin
                state_reg <= state_next;
                timer_reg <= timer_next;
                dir_reg   <= dir_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            timer_next = timer_reg;
            dir_next   = dir_reg;
            ovr_c      = 1'b0;
            blk_c      = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (step_req[gi] && enable_reg[gi]) begin
                        if (pend_valid_reg) begin
                            ovr_c = 1'b1;
                        end else if (es_mask_reg[gi] && es_active[gi] && !dir_req[gi]) begin
                            blk_c = 1'b1;
                        end else if (d != dir_reg) begin
                            dir_next   = d;
                            state_next = ST_SETUP;
                            timer_next = setup_eff;
                        end else begin
                            state_next = ST_HIGH;
                            timer_next = pulse_eff;
                        end
                    end
                end
                ST_SETUP, ST_HIGH: begin
                    if (timer_reg <= TIMER_WIDTH'(1)) begin
                        state_next = (state_reg == ST_SETUP) ? ST_HIGH : ST_LOW;
                        timer_next = pulse_eff;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
                default: begin
                    if (timer_reg <= TIMER_WIDTH'(1)) state_next = ST_IDLE;
                    else                              timer_next = timer_reg - 1'b1;
                end
            endcase
            if (state_reg != ST_IDLE && step_req[gi]) ovr_c = 1'b1;
        end

        always_comb begin
            step_c = (state_reg == ST_HIGH);
            idle_c = (state_reg == ST_IDLE);
        end

        assign mot_step[gi] = step_c;
        assign mot_dir[gi]  = dir_reg;
        assign idle[gi]     = idle_c;
        assign ovr_set[gi]  = ovr_c;
        assign blk_set[gi]  = blk_c;
    end
endmodule
